// File: rtl/intr_controller_if.sv
// Bus bundle between the MCU wrapper and the interrupt controller.
// Carries the peripheral request lines, the MCU IO-bus write side
// (port_id/out_port/io_strb), the read-data return and the INTR line.
//   master : MCU/wrapper side, drives requests and the IO bus
//   slave  : intr_controller side, returns read data and INTR
interface intr_controller_if #(
   parameter int N_SRC = 4
);
   logic [N_SRC-1:0] irq;
   logic [7:0]       port_id;
   logic [7:0]       out_port;
   logic             io_strb;
   logic [7:0]       in_data;
   logic             intr;

   modport master (
      output irq, port_id, out_port, io_strb,
      input  in_data, intr
   );

   modport slave (
      input  irq, port_id, out_port, io_strb,
      output in_data, intr
   );
endinterface

// File: rtl/intr_controller.sv
// Interrupt scheduler for the single MCU INTR input.
// Latches rising edges from up to 8 sources into a pending vector, gates
// them with a mask register and grants them round-robin, one at a time.
// Ports:
//   clk    in  system clock (MCU clock)
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: irq, port_id, out_port, io_strb in;
//          in_data (combinational read mux), intr out
//
// state  | meaning
// IDLE   | no interrupt outstanding, INTR=0, waiting for an eligible source
// ACTIVE | INTR=1 for source grant_q, waiting for an ack write
module intr_controller #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] MASK_ID   = 8'h60,
   parameter logic [7:0] ACK_ID    = 8'h61,
   parameter logic [7:0] STATUS_ID = 8'h62,
   parameter logic [7:0] PEND_ID   = 8'h63
) (
   input logic               clk,
   input logic               rst_n,
   intr_controller_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [2:0]       grant_q, grant_d;
   logic [2:0]       last_q,  last_d;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] elig;
   logic             mask_wr, ack_wr, ack_take;
   logic             win_found;
   logic [2:0]       win_idx;
   logic [3:0]       cand_sum;
   logic [2:0]       cand;

   assign mask_wr  = bus.io_strb && (bus.port_id == MASK_ID);
   assign ack_wr   = bus.io_strb && (bus.port_id == ACK_ID);
   assign ack_take = ack_wr && (state_q == ACTIVE);
   assign elig     = pend_q & mask_q;

   // Clear of the granted bit is applied first so a coincident new edge
   // on the same source survives.
   always_comb begin
      pend_d = pend_q;
      if (ack_take) begin
         for (int k = 0; k < N_SRC; k++) begin
            if (grant_q == 3'(k)) pend_d[k] = 1'b0;
         end
      end
      pend_d = pend_d | (bus.irq & ~irq_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q  <= '0;
         pend_q <= '0;
         mask_q <= '0;
      end else begin
         irq_q  <= bus.irq;
         pend_q <= pend_d;
         if (mask_wr) mask_q <= bus.out_port[N_SRC-1:0];
      end
   end

   // Round-robin: candidates last+1, last+2, ... wrapping at N_SRC; the
   // sum never exceeds 2*N_SRC-1 so a single subtraction wraps it.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         cand_sum = {1'b0, last_q} + 4'(i);
         if (cand_sum >= 4'(N_SRC)) cand_sum = cand_sum - 4'(N_SRC);
         cand = cand_sum[2:0];
         for (int k = 0; k < N_SRC; k++) begin
            if (!win_found && (cand == 3'(k)) && elig[k]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= 3'(N_SRC - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = ACTIVE;
               grant_d = win_idx;
               last_d  = win_idx;
            end
         end
         ACTIVE: begin
            if (ack_wr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.intr    = (state_q == ACTIVE);
      bus.in_data = 8'h00;
      case (bus.port_id)
         MASK_ID:   bus.in_data[N_SRC-1:0] = mask_q;
         STATUS_ID: bus.in_data = {(state_q == ACTIVE), 4'b0000, grant_q};
         PEND_ID:   bus.in_data[N_SRC-1:0] = pend_q;
         default:   bus.in_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: reset, masking, round robin,
// ack/edge collision, held level, stray writes, mask drop while active,
// and asynchronous reset while active.
module tb_intr_controller;

   localparam logic [7:0] MASK_ID   = 8'h60;
   localparam logic [7:0] ACK_ID    = 8'h61;
   localparam logic [7:0] STATUS_ID = 8'h62;
   localparam logic [7:0] PEND_ID   = 8'h63;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   n_int;
   logic [7:0] rv;

   intr_controller_if #(.N_SRC(4)) bus ();

   intr_controller #(.N_SRC(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] id, input logic [7:0] data);
      bus.port_id  = id;
      bus.out_port = data;
      bus.io_strb  = 1'b1;
      tick();
      bus.io_strb  = 1'b0;
      bus.port_id  = 8'h00;
      bus.out_port = 8'h00;
   endtask

   task automatic rd(input logic [7:0] id, output logic [7:0] val);
      bus.port_id = id;
      #1;
      val = bus.in_data;
      bus.port_id = 8'h00;
   endtask

   task automatic intr_is(input string tag, input logic exp);
      chk(tag, {7'b0, bus.intr}, {7'b0, exp});
   endtask

   initial begin
      n_chk = 0; n_fail = 0; n_int = 0;
      rst_n = 1'b0;
      bus.irq = '0; bus.port_id = '0; bus.out_port = '0; bus.io_strb = 1'b0;
      #23;
      intr_is("rst_intr", 1'b0);
      rd(MASK_ID, rv);   chk("rst_mask", rv, 8'h00);
      rd(STATUS_ID, rv); chk("rst_status", rv, 8'h00);
      rd(PEND_ID, rv);   chk("rst_pend", rv, 8'h00);
      rst_n = 1'b1;
      tick();

      // Round robin from reset (last=3): 1 before 3, then 0 before 3.
      wr(MASK_ID, 8'h0F);
      rd(MASK_ID, rv); chk("rr_mask", rv, 8'h0F);
      bus.irq = 4'b1010;
      tick();
      intr_is("rr_lat_k", 1'b0);
      tick();
      intr_is("rr_lat_k1", 1'b1);
      rd(STATUS_ID, rv); chk("rr_first", rv, 8'h81);
      bus.irq = 4'b0000;
      wr(ACK_ID, 8'h00);
      intr_is("rr_gap", 1'b0);
      tick();
      intr_is("rr_reassert", 1'b1);
      rd(STATUS_ID, rv); chk("rr_second", rv, 8'h83);
      wr(ACK_ID, 8'h00);
      intr_is("rr_done_intr", 1'b0);
      tick();
      intr_is("rr_done_intr2", 1'b0);
      rd(PEND_ID, rv); chk("rr_done_pend", rv, 8'h00);
      bus.irq = 4'b1001;
      tick(); tick();
      rd(STATUS_ID, rv); chk("rr_wrap", rv, 8'h80);
      bus.irq = 4'b0000;
      wr(ACK_ID, 8'h00);
      tick();
      rd(STATUS_ID, rv); chk("rr_wrap2", rv, 8'h83);
      wr(ACK_ID, 8'h00);
      tick();
      rd(PEND_ID, rv); chk("rr_wrap_pend", rv, 8'h00);

      // Masking: event latched while masked, granted one cycle after unmask.
      wr(MASK_ID, 8'h00);
      bus.irq = 4'b0100;
      tick();
      bus.irq = 4'b0000;
      tick(); tick(); tick();
      intr_is("mask_intr", 1'b0);
      rd(PEND_ID, rv); chk("mask_pend", rv, 8'h04);
      wr(MASK_ID, 8'h04);
      intr_is("mask_k", 1'b0);
      tick();
      intr_is("mask_k1", 1'b1);
      rd(STATUS_ID, rv); chk("mask_status", rv, 8'h82);
      wr(ACK_ID, 8'h00);
      tick();

      // Collision: new edge on the granted source in the ack cycle.
      bus.irq = 4'b0100;
      tick(); tick();
      rd(STATUS_ID, rv); chk("col_grant", rv, 8'h82);
      bus.irq = 4'b0000;
      tick();
      bus.irq = 4'b0100;
      wr(ACK_ID, 8'h00);
      intr_is("col_gap", 1'b0);
      rd(PEND_ID, rv); chk("col_pend", rv, 8'h04);
      tick();
      intr_is("col_reassert", 1'b1);
      rd(STATUS_ID, rv); chk("col_status", rv, 8'h82);
      bus.irq = 4'b0000;
      wr(ACK_ID, 8'h00);
      tick();
      rd(PEND_ID, rv); chk("col_clear", rv, 8'h00);

      // Held level: one interrupt for a 20-cycle high.
      wr(MASK_ID, 8'h0F);
      bus.irq = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.intr) begin
            n_int++;
            wr(ACK_ID, 8'h00);
         end
      end
      bus.irq = 4'b0000;
      tick(); tick();
      chk("held_count", 8'(n_int), 8'd1);
      intr_is("held_intr", 1'b0);

      // Stray ack while idle and writes to an unowned ID.
      wr(MASK_ID, 8'h00);
      bus.irq = 4'b0001;
      tick();
      bus.irq = 4'b0000;
      tick();
      wr(ACK_ID, 8'h00);
      tick();
      rd(PEND_ID, rv);   chk("stray_pend", rv, 8'h01);
      rd(STATUS_ID, rv); chk("stray_status", rv, 8'h00);
      wr(8'h40, 8'hFF);
      tick();
      rd(MASK_ID, rv);   chk("unowned_mask", rv, 8'h00);
      rd(8'h40, rv);     chk("unowned_read", rv, 8'h00);
      intr_is("unowned_intr", 1'b0);
      wr(MASK_ID, 8'h01);
      tick();
      wr(ACK_ID, 8'h00);
      tick();

      // Mask drop while active: grant 1 holds until ack, then stays low.
      wr(MASK_ID, 8'h0F);
      bus.irq = 4'b1010;
      tick(); tick();
      bus.irq = 4'b0000;
      rd(STATUS_ID, rv); chk("drop_grant", rv, 8'h81);
      wr(MASK_ID, 8'h00);
      tick(); tick();
      intr_is("drop_hold", 1'b1);
      wr(ACK_ID, 8'h00);
      tick(); tick();
      intr_is("drop_after", 1'b0);
      rd(PEND_ID, rv);   chk("drop_pend", rv, 8'h08);
      rd(STATUS_ID, rv); chk("drop_status", rv, 8'h01);
      wr(MASK_ID, 8'h08);
      tick();
      wr(ACK_ID, 8'h00);
      tick();

      // Asynchronous reset while active with pending=0x05.
      wr(MASK_ID, 8'h05);
      bus.irq = 4'b0101;
      tick(); tick();
      intr_is("arst_pre", 1'b1);
      rd(PEND_ID, rv); chk("arst_pre_pend", rv, 8'h05);
      #1;
      rst_n = 1'b0;
      #1;
      intr_is("arst_intr", 1'b0);
      rd(PEND_ID, rv);   chk("arst_pend", rv, 8'h00);
      rd(MASK_ID, rv);   chk("arst_mask", rv, 8'h00);
      rd(STATUS_ID, rv); chk("arst_status", rv, 8'h00);
      bus.irq = 4'b0000;
      tick();
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
